// File: rtl/shift_pkg.sv
// -----------------------------------------------------------------------------
// shift_pkg
//   Shared definitions for the shift-register family. This file holds the
//   operation-mode encodings, the burst FSM state encoding and a helper that
//   classifies which modes may run as multi-cycle bursts.
//
//   Contents:
//     MODE_*          3-bit operation select codes
//     ENC_IDLE/BUSY   FSM state encodings, also used as the enum values
//     state_t         FSM state type
//     is_burst_mode() 1 for the single-bit shift/rotate modes
// -----------------------------------------------------------------------------
package shift_pkg;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;
    localparam logic [MODE_W-1:0] MODE_LOAD = 3'b001;
    localparam logic [MODE_W-1:0] MODE_SHL  = 3'b010;
    localparam logic [MODE_W-1:0] MODE_SHR  = 3'b011;
    localparam logic [MODE_W-1:0] MODE_ROTL = 3'b100;
    localparam logic [MODE_W-1:0] MODE_ROTR = 3'b101;
    localparam logic [MODE_W-1:0] MODE_ASR  = 3'b110;
    localparam logic [MODE_W-1:0] MODE_RSVD = 3'b111;

    localparam logic [0:0] ENC_IDLE = 1'b0;
    localparam logic [0:0] ENC_BUSY = 1'b1;

    typedef enum logic [0:0] {
        ST_IDLE = ENC_IDLE,
        ST_BUSY = ENC_BUSY
    } state_t;

    // Only the single-bit shift/rotate operations are meaningful when
    // repeated; hold, load and the reserved code never start a burst.
    function automatic logic is_burst_mode(input logic [MODE_W-1:0] m);
        return (m == MODE_SHL)  || (m == MODE_SHR)  ||
               (m == MODE_ROTL) || (m == MODE_ROTR) ||
               (m == MODE_ASR);
    endfunction

endpackage

// File: rtl/shift_op.sv
// -----------------------------------------------------------------------------
// shift_op
//   Combinational single-bit operation on a WIDTH-bit word. The parent
//   register uses one instance for both single-cycle operations and each step
//   of a burst.
//
//   Ports:
//     mode   in   3      operation select (shift_pkg MODE_* codes)
//     q      in   WIDTH  current register value
//     sin_l  in   1      bit entering the MSB on a logical right shift
//     sin_r  in   1      bit entering the LSB on a left shift
//     q_nxt  out  WIDTH  result of one operation
//
//   Load is not handled here because it needs the parallel data; hold, load
//   and reserved all return q unchanged and the parent substitutes d.
// -----------------------------------------------------------------------------
module shift_op
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [MODE_W-1:0] mode,
    input  logic [WIDTH-1:0]  q,
    input  logic              sin_l,
    input  logic              sin_r,
    output logic [WIDTH-1:0]  q_nxt
);

    always_comb begin
        q_nxt = q;
        case (mode)
            MODE_SHL:  q_nxt = {q[WIDTH-2:0], sin_r};
            MODE_SHR:  q_nxt = {sin_l, q[WIDTH-1:1]};
            MODE_ROTL: q_nxt = {q[WIDTH-2:0], q[WIDTH-1]};
            MODE_ROTR: q_nxt = {q[0], q[WIDTH-1:1]};
            // Arithmetic right shift replicates the sign bit.
            MODE_ASR:  q_nxt = {q[WIDTH-1], q[WIDTH-1:1]};
            default:   q_nxt = q;
        endcase
    end

endmodule

// File: rtl/shift_reg_univ.sv
// -----------------------------------------------------------------------------
// shift_reg_univ
//   Universal shift register with single-cycle operations and a counted
//   burst mode. In IDLE, en applies one operation selected by mode. A start
//   with a shift/rotate mode latches mode and shamt and then repeats that
//   operation shamt times in BUSY, pulsing done for one cycle afterwards.
//
//   Handshake: start is a level sampled only in IDLE. It is accepted on any
//   edge where the FSM is IDLE and mode is a shift/rotate code; that includes
//   the cycle in which done is high, so bursts can run back-to-back. While
//   busy is high every control input except rst, sin_l and sin_r is ignored.
//
//   Ports:
//     clk        in   1      clock, rising edge
//     rst        in   1      synchronous active-high reset
//     en         in   1      single-cycle operation enable (IDLE only)
//     mode       in   3      operation select
//     d          in   WIDTH  parallel load data
//     sin_r      in   1      serial bit into the LSB on shl
//     sin_l      in   1      serial bit into the MSB on shr
//     start      in   1      burst request
//     shamt      in   CNT_W  burst length in single-bit operations
//     q          out  WIDTH  register contents
//     sout_l     out  1      q MSB
//     sout_r     out  1      q LSB
//     busy       out  1      burst in progress
//     done       out  1      one-cycle burst completion pulse
//     fsm_state  out  1      current FSM state, for observation
// -----------------------------------------------------------------------------
module shift_reg_univ
    import shift_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter int               CNT_W   = $clog2(WIDTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [MODE_W-1:0] mode,
    input  logic [WIDTH-1:0]  d,
    input  logic              sin_r,
    input  logic              sin_l,
    input  logic              start,
    input  logic [CNT_W-1:0]  shamt,
    output logic [WIDTH-1:0]  q,
    output logic              sout_l,
    output logic              sout_r,
    output logic              busy,
    output logic              done,
    output state_t            fsm_state
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   q_reg, q_nxt;
    logic [CNT_W-1:0]   count, count_nxt;
    logic [MODE_W-1:0]  mode_lat, mode_lat_nxt;
    logic               done_reg, done_nxt;

    logic [MODE_W-1:0]  op_mode;
    logic [WIDTH-1:0]   op_q;
    logic               accept;

    // The shared operator sees the latched mode during a burst and the live
    // mode otherwise.
    always_comb begin
        op_mode = mode;
        if (state == ST_BUSY) begin
            op_mode = mode_lat;
        end
    end

    shift_op #(
        .WIDTH (WIDTH)
    ) u_op (
        .mode  (op_mode),
        .q     (q_reg),
        .sin_l (sin_l),
        .sin_r (sin_r),
        .q_nxt (op_q)
    );

    // A start with hold/load/reserved is not a burst and falls through to the
    // en path.
    assign accept = start && is_burst_mode(mode);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            q_reg    <= RST_VAL;
            count    <= '0;
            mode_lat <= MODE_HOLD;
            done_reg <= 1'b0;
        end else begin
            state    <= state_nxt;
            q_reg    <= q_nxt;
            count    <= count_nxt;
            mode_lat <= mode_lat_nxt;
            done_reg <= done_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        q_nxt        = q_reg;
        count_nxt    = count;
        mode_lat_nxt = mode_lat;
        done_nxt     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    // q is left untouched on the accepting edge; the first
                    // operation happens on the following edge.
                    mode_lat_nxt = mode;
                    count_nxt    = shamt;
                    if (shamt != '0) begin
                        state_nxt = ST_BUSY;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end else if (en) begin
                    if (mode == MODE_LOAD) begin
                        q_nxt = d;
                    end else begin
                        q_nxt = op_q;
                    end
                end
            end

            ST_BUSY: begin
                q_nxt     = op_q;
                count_nxt = count - CNT_ONE;
                if (count == CNT_ONE) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign q         = q_reg;
    assign sout_l    = q_reg[WIDTH-1];
    assign sout_r    = q_reg[0];
    assign busy      = (state == ST_BUSY);
    assign done      = done_reg;
    assign fsm_state = state;

endmodule

// File: tb/tb_shift_reg_univ.sv
module tb_shift_reg_univ;
    import shift_pkg::*;

    localparam int         W     = 8;
    localparam int         CW    = $clog2(W) + 1;
    localparam logic [W-1:0] RV  = 8'hA5;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [2:0]    mode;
    logic [W-1:0]  d;
    logic          sin_r;
    logic          sin_l;
    logic          start;
    logic [CW-1:0] shamt;
    logic [W-1:0]  q;
    logic          sout_l;
    logic          sout_r;
    logic          busy;
    logic          done;
    state_t        fsm_state;

    always #5 clk = ~clk;

    shift_reg_univ #(
        .WIDTH   (W),
        .RST_VAL (RV),
        .CNT_W   (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .d         (d),
        .sin_r     (sin_r),
        .sin_l     (sin_l),
        .start     (start),
        .shamt     (shamt),
        .q         (q),
        .sout_l    (sout_l),
        .sout_r    (sout_r),
        .busy      (busy),
        .done      (done),
        .fsm_state (fsm_state)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_q(input string name);
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, got %0h", name, q);
        end else begin
            e = exp_q.pop_front();
            check(name, q, e);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic single_op(input logic [2:0] m, input logic e, input logic [W-1:0] dv,
                             input logic sl, input logic sr, input logic [W-1:0] exp);
        mode  = m;
        en    = e;
        d     = dv;
        sin_l = sl;
        sin_r = sr;
        start = 1'b0;
        exp_q.push_back(exp);
        tick();
        check_q("single_q");
        check("single_busy", busy, 0);
        check("single_done", done, 0);
        check("single_souts", {sout_l, sout_r}, {exp[W-1], exp[0]});
        en = 1'b0;
    endtask

    // Starts a burst and runs it to done. While busy, noisy en/mode/start/
    // shamt values are driven to show they are ignored.
    task automatic run_burst(input logic [2:0] m, input logic [CW-1:0] n,
                             input logic sl, input logic sr, input logic [W-1:0] exp);
        int lat;
        int bcyc;
        bit got;
        exp_q.push_back(exp);
        mode  = m;
        shamt = n;
        start = 1'b1;
        en    = 1'b0;
        sin_l = sl;
        sin_r = sr;
        lat   = 0;
        bcyc  = 0;
        got   = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            lat++;
            start = 1'b0;
            if (busy) begin
                bcyc++;
                start = 1'b1;
                en    = 1'b1;
                mode  = MODE_ROTR;
                shamt = CW'(2);
                d     = 8'h00;
            end else begin
                en   = 1'b0;
                mode = m;
            end
            if (done) got = 1'b1;
        end
        check("burst_done_seen", got, 1);
        check("burst_latency", lat, int'(n) + 1);
        check("burst_busy_cycles", bcyc, int'(n));
        check_q("burst_q");
    endtask

    // ---------------- table ----------------
    typedef struct {
        logic [2:0]   mode;
        logic         en;
        logic [W-1:0] d;
        logic         sin_l;
        logic         sin_r;
        logic [W-1:0] exp;
    } vec_t;

    vec_t vecs[12];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] pat;

        vecs[0]  = '{MODE_LOAD, 1'b1, 8'h81, 1'b0, 1'b0, 8'h81};
        vecs[1]  = '{MODE_ROTL, 1'b1, 8'h00, 1'b0, 1'b0, 8'h03};
        vecs[2]  = '{MODE_ROTR, 1'b1, 8'h00, 1'b0, 1'b0, 8'h81};
        vecs[3]  = '{MODE_SHL,  1'b1, 8'h00, 1'b0, 1'b1, 8'h03};
        vecs[4]  = '{MODE_SHR,  1'b1, 8'h00, 1'b1, 1'b0, 8'h81};
        vecs[5]  = '{MODE_ASR,  1'b1, 8'h00, 1'b0, 1'b0, 8'hC0};
        vecs[6]  = '{MODE_HOLD, 1'b1, 8'hFF, 1'b1, 1'b1, 8'hC0};
        vecs[7]  = '{MODE_RSVD, 1'b1, 8'hFF, 1'b1, 1'b1, 8'hC0};
        vecs[8]  = '{MODE_LOAD, 1'b0, 8'hFF, 1'b0, 1'b0, 8'hC0};
        vecs[9]  = '{MODE_LOAD, 1'b1, 8'h90, 1'b0, 1'b0, 8'h90};
        vecs[10] = '{MODE_SHR,  1'b1, 8'h00, 1'b0, 1'b1, 8'h48};
        vecs[11] = '{MODE_SHL,  1'b1, 8'h00, 1'b1, 1'b0, 8'h90};

        // reset
        rst   = 1'b1;
        en    = 1'b1;
        mode  = MODE_LOAD;
        d     = 8'h3C;
        sin_l = 1'b0;
        sin_r = 1'b0;
        start = 1'b1;
        shamt = CW'(3);
        tick();
        tick();
        check("rst_q", q, RV);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_state", fsm_state, ST_IDLE);
        rst   = 1'b0;
        start = 1'b0;
        en    = 1'b0;

        // single-cycle operations
        for (int i = 0; i < 12; i++) begin
            single_op(vecs[i].mode, vecs[i].en, vecs[i].d, vecs[i].sin_l, vecs[i].sin_r, vecs[i].exp);
        end

        // asr burst of 3 from 0x90, then done must drop after one cycle
        run_burst(MODE_ASR, CW'(3), 1'b0, 1'b0, 8'hF2);
        tick();
        check("asr_done_one_cycle", done, 0);
        check("asr_q_held", q, 8'hF2);

        // rotl wraps past WIDTH, then back-to-back zero-length burst
        single_op(MODE_LOAD, 1'b1, 8'h01, 1'b0, 1'b0, 8'h01);
        run_burst(MODE_ROTL, CW'(9), 1'b0, 1'b0, 8'h02);
        run_burst(MODE_ROTL, CW'(0), 1'b0, 1'b0, 8'h02);
        run_burst(MODE_SHR, CW'(10), 1'b1, 1'b0, 8'hFF);
        run_burst(MODE_SHL, CW'(8), 1'b1, 1'b0, 8'h00);
        single_op(MODE_LOAD, 1'b1, 8'h80, 1'b0, 1'b0, 8'h80);
        run_burst(MODE_ASR, CW'(12), 1'b0, 1'b0, 8'hFF);
        single_op(MODE_LOAD, 1'b1, 8'h01, 1'b0, 1'b0, 8'h01);
        run_burst(MODE_ROTR, CW'(3), 1'b0, 1'b0, 8'h20);

        // serial input sampled live during a burst
        single_op(MODE_LOAD, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00);
        mode  = MODE_SHL;
        shamt = CW'(4);
        start = 1'b1;
        sin_r = 1'b0;
        tick();
        start = 1'b0;
        check("live_accept_busy", busy, 1);
        check("live_accept_q", q, 8'h00);
        pat = 4'b1011;
        for (int i = 3; i >= 0; i--) begin
            sin_r = pat[i];
            tick();
        end
        check("live_q", q, 8'h0B);
        check("live_done", done, 1);
        check("live_busy", busy, 0);

        // reset in the middle of a burst aborts it with no done
        mode  = MODE_SHL;
        shamt = CW'(5);
        start = 1'b1;
        sin_r = 1'b1;
        tick();
        start = 1'b0;
        check("abort_busy1", busy, 1);
        tick();
        check("abort_busy2", busy, 1);
        check("abort_q_step", q, 8'h17);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_q", q, RV);
        check("abort_busy", busy, 0);
        check("abort_state", fsm_state, ST_IDLE);
        for (int i = 0; i < 4; i++) begin
            check("abort_no_done", done, 0);
            tick();
        end
        check("abort_q_hold", q, RV);

        // start with load mode falls back to the en path
        mode  = MODE_LOAD;
        en    = 1'b1;
        d     = 8'h3C;
        start = 1'b1;
        shamt = CW'(3);
        tick();
        check("start_load_q", q, 8'h3C);
        check("start_load_busy", busy, 0);
        check("start_load_done", done, 0);
        start = 1'b0;
        en    = 1'b0;
        tick();
        check("start_load_busy_after", busy, 0);
        check("start_load_done_after", done, 0);

        check("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_reg_univ.md
SHIFT_REG_UNIV -- requirements
Module: shift_reg_univ

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits (legal range 2 to 64).
REQ-002 Parameter RST_VAL, default 0, value q takes on reset (WIDTH bits).
REQ-003 Parameter CNT_W, default $clog2(WIDTH)+1, width of the burst shift-amount port.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 en  input  1  single-cycle operation enable, used only in IDLE.
REQ-007 mode  input  3  operation select: 000 hold, 001 load, 010 shl, 011 shr, 100 rotl, 101 rotr, 110 asr, 111 reserved (acts as hold).
REQ-008 d  input  WIDTH  parallel load data.
REQ-009 sin_r  input  1  serial fill bit entering the LSB on shl.
REQ-010 sin_l  input  1  serial fill bit entering the MSB on shr.
REQ-011 start  input  1  burst request: repeat mode for shamt cycles.
REQ-012 shamt  input  CNT_W  burst length in single-bit operations.
REQ-013 q  output  WIDTH  register contents.
REQ-014 sout_l  output  1  equals q[WIDTH-1], combinational from q.
REQ-015 sout_r  output  1  equals q[0], combinational from q.
REQ-016 busy  output  1  high while the FSM is in BUSY.
REQ-017 done  output  1  one-cycle pulse marking burst completion.

Function
REQ-018 The FSM SHALL have two states, IDLE and BUSY, held in a registered state variable.
REQ-019 In IDLE with start=0 and en=1, q SHALL take the mode result at the next edge: load q<=d; shl {q[W-2:0],sin_r}; shr {sin_l,q[W-1:1]}; rotl {q[W-2:0],q[W-1]}; rotr {q[0],q[W-1:1]}; asr {q[W-1],q[W-1:1]}; hold/reserved unchanged.
REQ-020 In IDLE with en=0 and start=0, q SHALL hold.
REQ-021 In IDLE, start=1 with mode in {shl,shr,rotl,rotr,asr} SHALL latch mode and shamt and leave q unchanged at that edge; start has priority over en.
REQ-022 On accepted start with shamt!=0, the FSM SHALL go to BUSY; with shamt=0 it SHALL stay in IDLE and assert done on the next cycle.
REQ-023 start with mode in {hold, load, reserved} SHALL be ignored and treated as start=0, so en and mode apply per REQ-019.
REQ-024 In BUSY, each edge SHALL apply one latched-mode operation and decrement the count; en, mode, d, start and shamt are ignored.
REQ-025 In BUSY, sin_l and sin_r SHALL be sampled live each cycle.
REQ-026 The edge that applies the final operation (count==1) SHALL return the FSM to IDLE and set done=1 for exactly the following cycle.
REQ-027 Start-to-done latency SHALL be shamt+1 cycles; busy SHALL be high for exactly shamt cycles.
REQ-028 shamt>=WIDTH SHALL be legal: rotations wrap modulo WIDTH, shl/shr fill fully with the serial bit, asr saturates to all sign bits.
REQ-029 A start asserted in the same cycle that done is high SHALL be accepted, allowing back-to-back bursts.

Reset
REQ-030 When rst=1 at a clock edge: q<=RST_VAL, state<=IDLE, count<=0, latched mode<=hold, done<=0, busy<=0; reset overrides all other inputs.
REQ-031 rst asserted mid-burst SHALL abort the burst without producing a done pulse.

Structure
REQ-032 Mode encodings and FSM state encodings SHALL be localparams in a shared package, shift_pkg, reused by later shift and pipeline blocks.
REQ-033 The single-bit operation SHALL be one combinational sub-module, shift_op (inputs mode, q, sin_l, sin_r; output next q), instantiated once and shared by the IDLE and BUSY paths.

Verification
REQ-034 The testbench SHALL cover these scenarios (WIDTH=8 unless stated):
- rst=1 for 2 cycles with RST_VAL=8'hA5 -> q=A5, busy=0, done=0.
- Load d=8'h81 with en=1 -> q=81; then rotl single-cycle -> q=03; rotr -> q=81.
- q=8'h90, start asr shamt=3 -> busy high 3 cycles, done pulses in cycle 4, q=F2.
- q=8'h01, start rotl shamt=9 -> q=02; start with shamt=0 -> done next cycle, q unchanged.
- Burst shl shamt=5 with rst asserted at busy cycle 2 -> q=RST_VAL, no done pulse.
- start while mode=load, en=1, d=8'h3C -> q=3C next cycle, busy never asserted.
